// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer and its neighbours.
// Holds the sequencer state encoding and the default select/dwell widths,
// which the downstream decoder bench reuses.
package scan_sequencer_pkg;

  localparam int SEL_WIDTH_DEF   = 4;
  localparam int DWELL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter used to time how long a scan index stays enabled.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   load        - load load_value into the counter (has priority over run)
//   run         - decrement by one per cycle while non-zero
//   load_value  - value loaded on load
//   zero        - high while the counter holds zero
module dwell_timer
  import scan_sequencer_pkg::*;
#(
  parameter int WIDTH = DWELL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: drives the registered select/enable pair of a 4-to-16
// decoder. Walks first..last (modulo 2^SEL_WIDTH), holding each index
// enabled for D cycles followed by one blanking cycle, in one-shot or
// continuous mode.
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   start, stop   - start sampled in IDLE only; stop honoured in any state
//   mode_oneshot  - 1: single pass then IDLE, 0: wrap continuously
//   first_sel, last_sel, dwell_cycles - range and dwell, latched at start
//   binary_out, enable_out - registered select and enable to the decoder
//   sel_strobe    - pulse on the first enabled cycle of each index
//   busy, done    - busy outside IDLE; done pulses at end of a one-shot pass
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int SEL_WIDTH   = SEL_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode_oneshot,
  input  logic [SEL_WIDTH-1:0]   first_sel,
  input  logic [SEL_WIDTH-1:0]   last_sel,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [SEL_WIDTH-1:0]   binary_out,
  output logic                   enable_out,
  output logic                   sel_strobe,
  output logic                   busy,
  output logic                   done
);

  scan_state_t            state;
  logic [SEL_WIDTH-1:0]   first_q;
  logic [SEL_WIDTH-1:0]   last_q;
  logic [DWELL_WIDTH-1:0] dwell_m1_q;
  logic                   oneshot_q;

  logic [DWELL_WIDTH-1:0] dwell_in_m1;
  logic                   at_last;
  logic                   timer_load;
  logic [DWELL_WIDTH-1:0] timer_value;
  logic                   timer_zero;

  // The timer holds D-1 so that zero is reached on the last enabled cycle;
  // a dwell of 0 is treated as 1.
  always_comb begin
    dwell_in_m1 = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_WIDTH'(1);
    at_last     = (binary_out == last_q);
    timer_load  = 1'b0;
    timer_value = dwell_m1_q;
    if (!stop) begin
      case (state)
        IDLE: begin
          timer_load  = start;
          timer_value = dwell_in_m1;
        end
        BLANK:   timer_load = !(at_last && oneshot_q);
        default: timer_load = 1'b0;
      endcase
    end
  end

  dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .run        (state == DWELL),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      binary_out <= '0;
      enable_out <= 1'b0;
      sel_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      first_q    <= '0;
      last_q     <= '0;
      dwell_m1_q <= '0;
      oneshot_q  <= 1'b0;
    end else begin
      sel_strobe <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        // Abort: binary_out deliberately keeps its last value.
        state      <= IDLE;
        enable_out <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              first_q    <= first_sel;
              last_q     <= last_sel;
              dwell_m1_q <= dwell_in_m1;
              oneshot_q  <= mode_oneshot;
              binary_out <= first_sel;
              enable_out <= 1'b1;
              sel_strobe <= 1'b1;
              busy       <= 1'b1;
              state      <= DWELL;
            end
          end
          DWELL: begin
            if (timer_zero) begin
              enable_out <= 1'b0;
              state      <= BLANK;
            end
          end
          BLANK: begin
            if (!at_last) begin
              binary_out <= binary_out + SEL_WIDTH'(1);
              enable_out <= 1'b1;
              sel_strobe <= 1'b1;
              state      <= DWELL;
            end else if (oneshot_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              binary_out <= first_q;
              enable_out <= 1'b1;
              sel_strobe <= 1'b1;
              state      <= DWELL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios plus randomized
// scans compared cycle by cycle against an arithmetic trace model.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode_oneshot;
  logic [3:0] first_sel;
  logic [3:0] last_sel;
  logic [7:0] dwell_cycles;
  logic [3:0] binary_out;
  logic       enable_out;
  logic       sel_strobe;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  // Model configuration for the scan currently being checked.
  int m_first, m_last, m_d, m_oneshot, m_abort_kind, m_abort_at;

  always #5 clk = ~clk;

  scan_sequencer #(.SEL_WIDTH(4), .DWELL_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mode_oneshot (mode_oneshot),
    .first_sel    (first_sel),
    .last_sel     (last_sel),
    .dwell_cycles (dwell_cycles),
    .binary_out   (binary_out),
    .enable_out   (enable_out),
    .sel_strobe   (sel_strobe),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observed();
    return {binary_out, enable_out, sel_strobe, busy, done};
  endfunction

  // Uninterrupted scan, cycle c counted from the first enabled cycle.
  // Returns {binary, enable, strobe, busy, done}.
  function automatic logic [7:0] base_trace(int c);
    int n, p, i, ph;
    n = ((m_last - m_first) & 15) + 1;
    p = m_d + 1;
    if (m_oneshot != 0 && c >= n * p)
      return {4'(m_last), 3'b000, (c == n * p)};
    i  = c / p;
    ph = c % p;
    if (m_oneshot == 0) i = i % n;
    return {4'((m_first + i) & 15), (ph < m_d), (ph == 0), 1'b1, 1'b0};
  endfunction

  // abort_kind: 0 none, 1 stop at cycle m_abort_at, 2 reset at that cycle.
  function automatic logic [7:0] model(int c);
    logic [7:0] t;
    if (m_abort_kind != 0 && c > m_abort_at) begin
      if (m_abort_kind == 2) return 8'h00;
      t = base_trace(m_abort_at);
      return {t[7:4], 4'b0000};
    end
    return base_trace(c);
  endfunction

  task automatic run_scan(input int f, input int l, input int dw, input int os,
                          input int abort_kind, input int abort_at, input int ncyc);
    logic [7:0] e;
    @(negedge clk);
    start        = 1'b1;
    stop         = 1'b0;
    first_sel    = 4'(f);
    last_sel     = 4'(l);
    dwell_cycles = 8'(dw);
    mode_oneshot = os[0];
    m_first      = f;
    m_last       = l;
    m_d          = (dw == 0) ? 1 : dw;
    m_oneshot    = os;
    m_abort_kind = abort_kind;
    m_abort_at   = abort_at;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = model(c);
      check_eq($sformatf("scan f=%0d l=%0d d=%0d os=%0d c=%0d", f, l, dw, os, c),
               32'(observed()), 32'(e));
      // While busy, toss in ignored starts and config changes.
      start        = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
      first_sel    = 4'($urandom);
      last_sel     = 4'($urandom);
      dwell_cycles = 8'($urandom);
      mode_oneshot = 1'($urandom);
      stop         = (abort_kind == 1 && c == abort_at);
      reset        = (abort_kind == 2 && c == abort_at);
    end
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle_checks(input int n, input logic [3:0] bin);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle k=%0d", k), 32'(observed()), 32'({bin, 4'b0000}));
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  initial begin
    int f, l, dw, os, n, p, ab;
    reset        = 1'b1;
    start        = 1'b1;
    stop         = 1'b0;
    mode_oneshot = 1'b1;
    first_sel    = 4'd7;
    last_sel     = 4'd9;
    dwell_cycles = 8'd3;

    // Reset held three cycles with start asserted.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("reset k=%0d", k), 32'(observed()), 32'h0);
    end
    reset = 1'b0;
    start = 1'b0;
    idle_checks(3, 4'd0);

    // One-shot 0..3, dwell 2: done 12 cycles after first enable.
    run_scan(0, 3, 2, 1, 0, -1, 15);
    // Wrap 14..1 with dwell 0 (treated as 1).
    run_scan(14, 1, 0, 1, 0, -1, 11);
    // Continuous 5,6 dwell 3; stop during second dwell of index 6.
    run_scan(5, 6, 3, 0, 1, 13, 18);

    // start and stop together in IDLE: stays idle, select held at 6.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    idle_checks(4, 4'd6);

    // Reset during dwell of index 2, then a clean start at 9.
    run_scan(0, 3, 2, 1, 2, 6, 9);
    run_scan(9, 11, 1, 1, 0, -1, 9);

    // Randomized scans, some aborted by stop.
    for (int it = 0; it < 25; it++) begin
      f  = $urandom_range(0, 15);
      l  = $urandom_range(0, 15);
      dw = $urandom_range(0, 4);
      os = $urandom_range(0, 1);
      n  = ((l - f) & 15) + 1;
      p  = ((dw == 0) ? 1 : dw) + 1;
      if (os == 1) begin
        if ($urandom_range(0, 3) == 0) begin
          ab = $urandom_range(0, n * p - 1);
          run_scan(f, l, dw, os, 1, ab, ab + 4);
        end else begin
          run_scan(f, l, dw, os, 0, -1, n * p + 3);
        end
      end else begin
        ab = $urandom_range(0, 2 * n * p);
        run_scan(f, l, dw, os, 1, ab, ab + 4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream stage of the 4-to-16 decoder.
- Generates the registered binary select and enable that drive the decoder's binary_in and enable inputs.
- Steps through a programmable index range (first..last, modulo 16), holding each index for a programmable dwell and inserting one blanking cycle (enable low) between indices to prevent ghosting on scanned rows and digits.
- Supports one-shot and continuous scan, with start/stop control and busy/done/strobe status.

Parameters:
- SEL_WIDTH, 4, width of the select index; the decoder is 2^SEL_WIDTH outputs wide.
- DWELL_WIDTH, 8, width of the dwell-cycle count.

Ports:
- clk  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a scan; sampled in IDLE only
- stop  input  1  abort the scan; honoured in any state
- mode_oneshot  input  1  1 = single pass then IDLE; 0 = continuous wrap
- first_sel  input  SEL_WIDTH  first index of the range; latched at start
- last_sel  input  SEL_WIDTH  last index of the range; latched at start
- dwell_cycles  input  DWELL_WIDTH  enable-high cycles per index; latched at start
- binary_out  output  SEL_WIDTH  registered select to decoder binary_in
- enable_out  output  1  registered enable to decoder enable
- sel_strobe  output  1  one-cycle pulse on the first cycle each new index is enabled
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse at the end of a one-shot pass

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE; binary_out=0, enable_out=0, sel_strobe=0, busy=0, done=0; dwell counter=0; latched config=0. Reset overrides every other input, including mid-scan.
- Effective dwell: D = (dwell_cycles==0) ? 1 : dwell_cycles.
- States: IDLE, DWELL, BLANK.
- IDLE, start=1 and stop=0:
  - Latch first/last/D/mode.
  - After the edge: binary_out=first_sel, enable_out=1, sel_strobe=1, busy=1, state=DWELL, counter=D-1.
- DWELL:
  - enable_out stays 1 for exactly D cycles.
  - counter decrements each cycle.
  - On counter==0: next state BLANK, enable_out=0.
  - binary_out holds throughout DWELL and BLANK.
- BLANK (exactly 1 cycle, enable_out=0):
  - If index != last: binary_out = index+1 mod 2^SEL_WIDTH (15 wraps to 0); enable_out=1; sel_strobe=1; reload counter; go to DWELL.
  - If index == last and one-shot: go to IDLE; done=1 for one cycle; busy=0 in the same cycle as done.
  - If index == last and continuous: binary_out=first, re-enter DWELL with sel_strobe.
- Period per index: D+1 cycles. A one-shot pass over N indices takes N*(D+1) cycles from the first enable to done.
- Range wrap: first>last is legal and scans through 15→0 (e.g. 14,15,0,1). first==last scans one index.
- stop=1 in any state:
  - Next cycle: state=IDLE, enable_out=0, busy=0, no done, binary_out holds its last value.
  - stop and start in the same cycle in IDLE: stop wins, the block stays IDLE.
- start while busy is ignored. Config-input changes while busy are ignored (only latched values are used).
- Invariant: enable_out=1 only in DWELL. binary_out never changes while enable_out=1.

Decomposition:
- Shared include file holds:
  - the state encoding localparams (IDLE=2'd0, DWELL=2'd1, BLANK=2'd2);
  - the DWELL_WIDTH/SEL_WIDTH defaults, also used by the decoder bench.
- One sub-module is natural: dwell_timer.
  - Loadable down-counter with load, value and zero-flag.
  - Also reusable by later display/keypad scan blocks.
- FSM and index register stay in scan_sequencer.

Test Plan:
- Reset values: assert reset 3 cycles with start=1 → all outputs 0, busy=0. Release reset → IDLE until the next start.
- One-shot, first=0, last=3, dwell=2:
  - binary_out sequence 0,1,2,3, each with enable high 2 cycles then low 1.
  - 4 sel_strobe pulses.
  - done pulses 12 cycles after the first enable.
  - A decoder attached downstream shows one-hot 0x0001,0x0002,0x0004,0x0008 only while enabled.
- Wrap and dwell zero: first=14, last=1, dwell=0, one-shot → indices 14,15,0,1, each enabled 1 cycle with 1 blank cycle; done after 8 cycles.
- Continuous plus stop:
  - first=5, last=6, dwell=3, continuous → 5,6,5,6…
  - Assert stop during the second dwell of index 6 → enable_out=0 next cycle, busy=0, no done pulse, binary_out stays 6.
- Start while busy and start+stop: start pulsed during DWELL with different config → sequence unchanged. start+stop together in IDLE → stays IDLE.
- Reset mid-operation: reset during DWELL of index 2 → next cycle all outputs 0, IDLE. A new start with first=9 then begins cleanly at 9.
